// File: rtl/add_seq_3b.sv
// Multi-cycle WIDTH-bit adder built from one shared 3-bit ripple slice.
// Operands are latched on an input handshake and summed LSB slice first, one slice per clock.
module full_add_3b (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  input  logic       cin_i,
  output logic [2:0] sum_o,
  output logic [2:0] cout_o
);
  logic [3:0] c;

  assign c[0] = cin_i;
  for (genvar i = 0; i < 3; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign cout_o = c[3:1];
endmodule

module add_seq_3b #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 3;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH < 3 || (WIDTH % 3) != 0) begin : g_bad_width
    $error("add_seq_3b: WIDTH must be a multiple of 3 and at least 3");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [NSLICE-1:0][2:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                   c_q, c_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [2:0]             a_sl, b_sl, fa_sum, fa_co;
  logic [1:0]             unused_co;
  logic                   last_slice;

  assign last_slice = (idx_q == IW'(NSLICE - 1));

  // Slice mux written as a compare loop so NSLICE=1 needs no special indexing
  always_comb begin
    a_sl = a_q[0];
    b_sl = b_q[0];
    for (int s = 0; s < NSLICE; s++) begin
      if (idx_q == IW'(s)) begin
        a_sl = a_q[s];
        b_sl = b_q[s];
      end
    end
  end

  full_add_3b u_fa (
    .a_i   (a_sl),
    .b_i   (b_sl),
    .cin_i (c_q),
    .sum_o (fa_sum),
    .cout_o(fa_co)
  );
  assign unused_co = fa_co[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid)   state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    idx_d = idx_q;
    sum_d = sum_q;
    if (state_q == S_IDLE && in_valid) begin
      a_d   = a;
      b_d   = b;
      c_d   = cin;
      idx_d = '0;
    end
    if (state_q == S_RUN) begin
      for (int s = 0; s < NSLICE; s++) begin
        if (idx_q == IW'(s)) sum_d[s] = fa_sum;
      end
      c_d = fa_co[2];
      if (!last_slice) idx_d = idx_q + IW'(1);
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    sum       = sum_q;
    cout      = c_q;
  end
endmodule

// File: tb/tb_add_seq_3b.sv
// Randomized bench for add_seq_3b at WIDTH=12 and WIDTH=3 against an a+b+cin model.
module tb_add_seq_3b;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        use3 = 1'b0;
  logic        tv = 1'b0, tro = 1'b0, tc = 1'b0;
  logic [11:0] ta = '0, tb_v = '0;

  logic        iv12, ir12, ov12, or12, co12, busy12;
  logic [11:0] s12;
  logic        iv3, ir3, ov3, or3, co3, busy3;
  logic [2:0]  s3;

  assign iv12 = tv & ~use3;
  assign or12 = tro & ~use3;
  assign iv3  = tv & use3;
  assign or3  = tro & use3;

  add_seq_3b #(.WIDTH(12)) u12 (
    .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .a(ta), .b(tb_v), .cin(tc),
    .out_valid(ov12), .out_ready(or12), .sum(s12), .cout(co12), .busy(busy12)
  );
  add_seq_3b #(.WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(ta[2:0]), .b(tb_v[2:0]), .cin(tc),
    .out_valid(ov3), .out_ready(or3), .sum(s3), .cout(co3), .busy(busy3)
  );

  logic        m_ir, m_ov, m_co, m_busy;
  logic [11:0] m_sum;
  assign m_ir   = use3 ? ir3   : ir12;
  assign m_ov   = use3 ? ov3   : ov12;
  assign m_co   = use3 ? co3   : co12;
  assign m_busy = use3 ? busy3 : busy12;
  assign m_sum  = use3 ? {9'b0, s3} : s12;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t (w=%0d): got %0h want %0h", tag, $time, use3 ? 3 : 12, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", m_ir, 1);
    chk("rst_out_valid", m_ov, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_sum", m_sum, 0);
    chk("rst_cout", m_co, 0);
  endtask

  // Model: {cout,sum} = a + b + cin as an unsigned (w+1)-bit number
  task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic ci, input int hold);
    int w, mask, e, n, exp_sum, exp_co;
    w       = use3 ? 3 : 12;
    mask    = (1 << w) - 1;
    e       = (int'(a) & mask) + (int'(b) & mask) + int'(ci);
    exp_sum = e & mask;
    exp_co  = (e >> w) & 1;
    @(negedge clk);
    ta = a; tb_v = b; tc = ci; tv = 1'b1;
    n = 0;
    while (!m_ir && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", m_ir, 1);
    @(negedge clk);
    tv = 1'b0;
    n = 0;
    while (!m_ov && n < 50) begin @(negedge clk); n++; end
    chk("latency", n, use3 ? 1 : 4);
    for (int h = 0; h < hold; h++) begin
      tv = 1'b1; ta = 12'($urandom); tb_v = 12'($urandom); tc = 1'($urandom);
      chk("hold_sum", m_sum, exp_sum);
      chk("hold_cout", m_co, exp_co);
      chk("hold_in_ready", m_ir, 0);
      @(negedge clk);
    end
    tv = 1'b0;
    chk("out_valid", m_ov, 1);
    chk("sum", m_sum, exp_sum);
    chk("cout", m_co, exp_co);
    tro = 1'b1;
    @(negedge clk);
    tro = 1'b0;
    chk("post_hs_idle", m_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog @%0t: bench did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, hs_t;
    int acc_t[2];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    use3 = 1'b0; chk_reset();
    use3 = 1'b1; chk_reset();

    use3 = 1'b0;
    run_op(12'h0FF, 12'h001, 1'b0, 0);
    run_op(12'hFFF, 12'h001, 1'b0, 0);
    run_op(12'hFFF, 12'hFFF, 1'b1, 0);
    run_op(12'h123, 12'h456, 1'b0, 6);

    // Reset two cycles after acceptance discards the operation
    @(negedge clk);
    ta = 12'h0AA; tb_v = 12'h055; tc = 1'b1; tv = 1'b1;
    @(negedge clk);
    tv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_no_out", m_ov, 0);
    end
    run_op(12'h007, 12'h001, 1'b0, 0);

    // Back-to-back with out_ready held high
    @(negedge clk);
    ta = 12'h800; tb_v = 12'h800; tc = 1'b0; tv = 1'b1; tro = 1'b1;
    acc = 0; hs_t = -1; acc_t[0] = -100; acc_t[1] = -100;
    for (int t = 0; t < 40 && acc < 2; t++) begin
      if (tv && m_ir) begin acc_t[acc] = t; acc++; end
      if (m_ov && hs_t < 0) begin
        hs_t = t;
        chk("b2b_sum1", m_sum, 12'h000);
        chk("b2b_cout1", m_co, 1);
      end
      @(negedge clk);
      if (acc == 1) begin ta = 12'h001; tb_v = 12'h002; tc = 1'b1; end
      if (acc == 2) tv = 1'b0;
    end
    chk("b2b_gap", acc_t[1], hs_t + 1);
    begin
      int n;
      n = 0;
      while (!m_ov && n < 50) begin @(negedge clk); n++; end
    end
    chk("b2b_sum2", m_sum, 12'h004);
    chk("b2b_cout2", m_co, 0);
    @(negedge clk);
    tro = 1'b0;

    for (int i = 0; i < 40; i++)
      run_op(12'($urandom), 12'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    use3 = 1'b1;
    run_op(12'h007, 12'h007, 1'b1, 0);
    run_op(12'h007, 12'h001, 1'b0, 2);
    for (int i = 0; i < 25; i++)
      run_op(12'($urandom), 12'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
